spi_slave_sync: RTL and testbench

SPI_SLAVE_SYNC -- requirements
Module: spi_slave_sync

---
 rtl/spi_slave_sync_pkg.sv | 23 ++
 rtl/spi_sync_edge.sv | 38 +++
 rtl/spi_slave_sync.sv | 221 ++++++++++++++++++++++
 tb/tb_spi_slave_sync.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_slave_sync_pkg.sv
// Shared types and constants for the clk-domain SPI slave.
package spi_slave_sync_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic {
        ST_IDLE,
        ST_SHIFT
    } spi_state_e;

    // Return a byte in wire order, so bit BYTE_W-1 always goes out first.
    function automatic logic [BYTE_W-1:0] tx_order(
        input logic [BYTE_W-1:0] b,
        input logic              msb_first
    );
        logic [BYTE_W-1:0] r;
        for (int i = 0; i < BYTE_W; i++) begin
            r[i] = b[BYTE_W-1-i];
        end
        return msb_first ? b : r;
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer with a delayed copy for rise/fall pulse detection.
module spi_sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rstb,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;
    logic              prev_q;
    logic              prev_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], din};
        prev_d = sync_q[STAGES-1];
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            sync_q <= {STAGES{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign level = sync_q[STAGES-1];
    assign rise  = level & ~prev_q;
    assign fall  = ~level & prev_q;

endmodule

// File: rtl/spi_slave_sync.sv
// Mode-0 SPI slave oversampled by clk: rx/tx byte paths, framing, tx holding register.
module spi_slave_sync
    import spi_slave_sync_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rstb,
    input  logic              mlb,
    input  logic              ss,
    input  logic              sck,
    input  logic              sdin,
    output logic              sdout,
    output logic [BYTE_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic [BYTE_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [CNT_W-1:0]  byte_count,
    output logic              frame_start,
    output logic              frame_end,
    output logic              underrun
);

    logic ss_lvl, ss_rise, ss_fall;
    logic sck_lvl, sck_rise, sck_fall;
    logic sdin_s;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ss_sync (
        .clk   (clk),
        .rstb  (rstb),
        .din   (ss),
        .level (ss_lvl),
        .rise  (ss_rise),
        .fall  (ss_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck_sync (
        .clk   (clk),
        .rstb  (rstb),
        .din   (sck),
        .level (sck_lvl),
        .rise  (sck_rise),
        .fall  (sck_fall)
    );

    logic [SYNC_STAGES-1:0] sdin_q, sdin_d;
    logic [SYNC_STAGES:0]   flush_q, flush_d;
    logic                   armed_q, armed_d;
    spi_state_e             state_q, state_d;
    logic                   mlb_q, mlb_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic [BYTE_W-1:0]      rx_sr_q, rx_sr_d;
    logic [BYTE_W-1:0]      rx_data_q, rx_data_d;
    logic                   rx_valid_q, rx_valid_d;
    logic [CNT_W-1:0]       byte_count_q, byte_count_d;
    logic [BYTE_W-1:0]      tx_sr_q, tx_sr_d;
    logic                   sdout_q, sdout_d;
    logic [BYTE_W-1:0]      hold_q, hold_d;
    logic                   hold_full_q, hold_full_d;
    logic                   ur_seen_q, ur_seen_d;
    logic                   underrun_q, underrun_d;
    logic                   frame_start_q, frame_start_d;
    logic                   frame_end_q, frame_end_d;

    logic              starting;
    logic              reload;
    logic              reload_msb;
    logic [BYTE_W-1:0] next_byte;
    logic [BYTE_W-1:0] next_ord;

    assign sdin_s = sdin_q[SYNC_STAGES-1];

    always_comb begin
        sdin_d        = {sdin_q[SYNC_STAGES-2:0], sdin};
        flush_d       = {flush_q[SYNC_STAGES-1:0], 1'b1};
        // Arm only once the ss pipeline holds real samples and ss is high,
        // so a reset released mid-frame cannot fake a frame start.
        armed_d       = armed_q | (flush_q[SYNC_STAGES] & ss_lvl);
        state_d       = state_q;
        mlb_d         = mlb_q;
        bit_cnt_d     = bit_cnt_q;
        rx_sr_d       = rx_sr_q;
        rx_data_d     = rx_data_q;
        rx_valid_d    = 1'b0;
        byte_count_d  = byte_count_q;
        tx_sr_d       = tx_sr_q;
        sdout_d       = sdout_q;
        hold_d        = hold_q;
        hold_full_d   = hold_full_q;
        ur_seen_d     = ur_seen_q;
        underrun_d    = 1'b0;
        frame_start_d = 1'b0;
        frame_end_d   = 1'b0;
        starting      = 1'b0;
        reload        = 1'b0;
        reload_msb    = mlb_q;
        next_byte     = '1;
        next_ord      = '1;

        if (tx_valid && !hold_full_q) begin
            hold_d      = tx_data;
            hold_full_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                sdout_d = 1'b0;
                // mode 0: sck must idle low when the frame opens
                if (ss_fall && armed_q && !sck_lvl) begin
                    state_d       = ST_SHIFT;
                    starting      = 1'b1;
                    bit_cnt_d     = 3'd0;
                    byte_count_d  = '0;
                    mlb_d         = mlb;
                    frame_start_d = 1'b1;
                    ur_seen_d     = 1'b0;
                    reload        = 1'b1;
                    reload_msb    = mlb;
                end
            end
            ST_SHIFT: begin
                if (ss_rise) begin
                    state_d     = ST_IDLE;
                    frame_end_d = 1'b1;
                    sdout_d     = 1'b0;
                end else if (sck_rise) begin
                    rx_sr_d   = mlb_q ? {rx_sr_q[BYTE_W-2:0], sdin_s}
                                      : {sdin_s, rx_sr_q[BYTE_W-1:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        rx_data_d  = rx_sr_d;
                        rx_valid_d = 1'b1;
                        reload     = 1'b1;
                        if (byte_count_q != '1) begin
                            byte_count_d = byte_count_q + CNT_W'(1);
                        end
                    end
                end else if (sck_fall) begin
                    sdout_d = tx_sr_q[BYTE_W-1];
                    tx_sr_d = tx_sr_q << 1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (reload) begin
            if (hold_full_q) begin
                next_byte   = hold_q;
                hold_full_d = 1'b0;
            end else if (tx_valid) begin
                next_byte   = tx_data;
                hold_full_d = 1'b0;
            end else begin
                // one underrun report per frame; later empty reloads just send 0xFF
                underrun_d = starting | ~ur_seen_q;
                ur_seen_d  = 1'b1;
            end
            next_ord = tx_order(next_byte, reload_msb);
            if (starting) begin
                sdout_d = next_ord[BYTE_W-1];
                tx_sr_d = next_ord << 1;
            end else begin
                tx_sr_d = next_ord;
            end
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            sdin_q        <= '0;
            flush_q       <= '0;
            armed_q       <= 1'b0;
            state_q       <= ST_IDLE;
            mlb_q         <= 1'b1;
            bit_cnt_q     <= 3'd0;
            rx_sr_q       <= '0;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            byte_count_q  <= '0;
            tx_sr_q       <= '0;
            sdout_q       <= 1'b0;
            hold_q        <= '0;
            hold_full_q   <= 1'b0;
            ur_seen_q     <= 1'b0;
            underrun_q    <= 1'b0;
            frame_start_q <= 1'b0;
            frame_end_q   <= 1'b0;
        end else begin
            sdin_q        <= sdin_d;
            flush_q       <= flush_d;
            armed_q       <= armed_d;
            state_q       <= state_d;
            mlb_q         <= mlb_d;
            bit_cnt_q     <= bit_cnt_d;
            rx_sr_q       <= rx_sr_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            byte_count_q  <= byte_count_d;
            tx_sr_q       <= tx_sr_d;
            sdout_q       <= sdout_d;
            hold_q        <= hold_d;
            hold_full_q   <= hold_full_d;
            ur_seen_q     <= ur_seen_d;
            underrun_q    <= underrun_d;
            frame_start_q <= frame_start_d;
            frame_end_q   <= frame_end_d;
        end
    end

    assign sdout       = sdout_q;
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign tx_ready    = ~hold_full_q;
    assign byte_count  = byte_count_q;
    assign frame_start = frame_start_q;
    assign frame_end   = frame_end_q;
    assign underrun    = underrun_q;

endmodule

// File: tb/tb_spi_slave_sync.sv
// Randomized bench: a bit-level SPI master plus a byte-level reference model.
module tb_spi_slave_sync;

    logic        clk = 1'b0;
    logic        rstb = 1'b0;
    logic        mlb = 1'b1;
    logic        ss = 1'b1;
    logic        sck = 1'b0;
    logic        sdin = 1'b0;
    logic        sdout;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data = 8'h00;
    logic        tx_valid = 1'b0;
    logic        tx_ready;
    logic [15:0] byte_count;
    logic        frame_start;
    logic        frame_end;
    logic        underrun;

    spi_slave_sync #(.SYNC_STAGES(2), .CNT_W(16)) dut (
        .clk         (clk),
        .rstb        (rstb),
        .mlb         (mlb),
        .ss          (ss),
        .sck         (sck),
        .sdin        (sdin),
        .sdout       (sdout),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .byte_count  (byte_count),
        .frame_start (frame_start),
        .frame_end   (frame_end),
        .underrun    (underrun)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    int         rxv_cnt, fs_cnt, fe_cnt, ur_cnt;
    logic [7:0] rx_got[$];

    always @(negedge clk) begin
        if (rx_valid) begin
            rxv_cnt++;
            rx_got.push_back(rx_data);
        end
        if (frame_start) fs_cnt++;
        if (frame_end)   fe_cnt++;
        if (underrun)    ur_cnt++;
    end

    task automatic clr_mon();
        rxv_cnt = 0;
        fs_cnt  = 0;
        fe_cnt  = 0;
        ur_cnt  = 0;
        rx_got.delete();
    endtask

    logic [7:0] mosi_q[$];
    logic [7:0] tx_q[$];
    logic [7:0] miso_got[$];
    logic [7:0] last_rx;

    task automatic wclk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_tx(input logic [7:0] b);
        int k = 0;
        tx_data = b;
        @(negedge clk);
        while (!tx_ready && k < 4000) begin
            @(negedge clk);
            k++;
        end
        if (!tx_ready) begin
            chk("tx_wait", 32'(tx_ready), 32'd1);
        end else begin
            tx_valid = 1'b1;
            @(posedge clk);
            #1 tx_valid = 1'b0;
        end
    endtask

    task automatic feed(input int from);
        for (int i = from; i < tx_q.size(); i++) push_tx(tx_q[i]);
    endtask

    task automatic ss_down(input bit m);
        mlb = m;
        ss  = 1'b0;
        wclk(8);
    endtask

    task automatic ss_up();
        wclk(8);
        ss = 1'b1;
        wclk(12);
    endtask

    task automatic send_bits(input logic [7:0] b, input int n, input bit m,
                             output logic [7:0] got);
        logic s;
        got = 8'h00;
        for (int i = 0; i < n; i++) begin
            sdin = m ? b[7-i] : b[i];
            wclk(8);
            s   = sdout;
            got = m ? {got[6:0], s} : {s, got[7:1]};
            sck = 1'b1;
            wclk(8);
            sck = 1'b0;
        end
    endtask

    task automatic run_frame(input bit m, input string tag);
        logic [7:0] g;
        int         nb;
        int         ntx;
        logic [7:0] exp_b;
        nb  = mosi_q.size();
        ntx = tx_q.size();
        clr_mon();
        miso_got.delete();
        if (ntx > 0) begin
            push_tx(tx_q[0]);
            chk({tag, "_rdy_drop"}, 32'(tx_ready), 32'd0);
        end
        fork
            if (ntx > 1) feed(1);
            begin
                ss_down(m);
                for (int i = 0; i < nb; i++) begin
                    send_bits(mosi_q[i], 8, m, g);
                    miso_got.push_back(g);
                end
                ss_up();
            end
        join
        if (nb > 0) last_rx = mosi_q[nb-1];
        chk({tag, "_rxv"}, 32'(rxv_cnt), 32'(nb));
        for (int i = 0; i < nb; i++) begin
            chk({tag, "_rx"}, (i < rx_got.size()) ? 32'(rx_got[i]) : 32'hdead,
                32'(mosi_q[i]));
            exp_b = (i < ntx) ? tx_q[i] : 8'hFF;
            chk({tag, "_miso"}, 32'(miso_got[i]), 32'(exp_b));
        end
        chk({tag, "_ur"}, 32'(ur_cnt), (ntx < nb + 1) ? 32'd1 : 32'd0);
        chk({tag, "_fs"}, 32'(fs_cnt), 32'd1);
        chk({tag, "_fe"}, 32'(fe_cnt), 32'd1);
        chk({tag, "_bcnt"}, 32'(byte_count), 32'(nb));
        chk({tag, "_sdout_idle"}, 32'(sdout), 32'd0);
        chk({tag, "_rxdata"}, 32'(rx_data), 32'(last_rx));
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_sdout"}, 32'(sdout), 32'd0);
        chk({tag, "_rxdata"}, 32'(rx_data), 32'd0);
        chk({tag, "_rxv"}, 32'(rx_valid), 32'd0);
        chk({tag, "_txrdy"}, 32'(tx_ready), 32'd1);
        chk({tag, "_bcnt"}, 32'(byte_count), 32'd0);
        chk({tag, "_fs"}, 32'(frame_start), 32'd0);
        chk({tag, "_fe"}, 32'(frame_end), 32'd0);
        chk({tag, "_ur"}, 32'(underrun), 32'd0);
    endtask

    initial begin
        #2ms;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] g;
        int         nb;
        int         ntx;
        bit         m;
        clr_mon();
        last_rx = 8'h00;
        wclk(3);
        chk_reset("rst");
        rstb = 1'b1;
        wclk(10);

        mosi_q = '{8'h7C};
        tx_q.delete();
        run_frame(1'b1, "msb7c");

        mosi_q = '{8'h1C};
        tx_q   = '{8'hA5};
        run_frame(1'b0, "lsb1c");

        mosi_q = '{8'h11, 8'h22, 8'h33};
        tx_q   = '{8'h01, 8'h02};
        run_frame(1'b1, "three");

        clr_mon();
        tx_q.delete();
        ss_down(1'b1);
        send_bits(8'h5A, 5, 1'b1, g);
        ss_up();
        chk("abort_rxv", 32'(rxv_cnt), 32'd0);
        chk("abort_rxdata", 32'(rx_data), 32'(last_rx));
        chk("abort_fe", 32'(fe_cnt), 32'd1);
        chk("abort_bcnt", 32'(byte_count), 32'd0);
        mosi_q = '{8'hE3};
        run_frame(1'b1, "after_abort");

        for (int f = 0; f < 10; f++) begin
            nb  = $urandom_range(1, 4);
            ntx = $urandom_range(0, nb + 1);
            m   = 1'($urandom_range(0, 1));
            mosi_q.delete();
            tx_q.delete();
            for (int i = 0; i < nb; i++) mosi_q.push_back(8'($urandom));
            for (int i = 0; i < ntx; i++) tx_q.push_back(8'($urandom));
            run_frame(m, $sformatf("rnd%0d", f));
        end

        clr_mon();
        ss_down(1'b1);
        send_bits(8'h55, 4, 1'b1, g);
        rstb = 1'b0;
        wclk(2);
        chk_reset("midrst");
        last_rx = 8'h00;
        rstb = 1'b1;
        clr_mon();
        send_bits(8'h55, 4, 1'b1, g);
        wclk(10);
        chk("midrst_no_fs", 32'(fs_cnt), 32'd0);
        chk("midrst_no_rxv", 32'(rxv_cnt), 32'd0);
        ss_up();
        mosi_q = '{8'hAA};
        tx_q.delete();
        run_frame(1'b1, "post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
